mu0_reg_multi: RTL and testbench



---
 rtl/mu0_reg_pkg.sv | 22 ++
 rtl/mu0_reg_next.sv | 97 +++++++++
 rtl/mu0_reg_multi.sv | 77 +++++++
 tb/tb_mu0_reg_multi.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mu0_reg_pkg.sv
// ---------------------------------------------------------------------------
// mu0_reg_pkg
// Shared types for the MU0 multi-mode register.
//   reg_mode_t : 3-bit operation select, fully decoded (all eight codes used)
//   MODE_W     : width of the Mode field
// ---------------------------------------------------------------------------
package mu0_reg_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        HOLD = 3'd0,
        LOAD = 3'd1,
        INC  = 3'd2,
        DEC  = 3'd3,
        SHL  = 3'd4,
        SHR  = 3'd5,
        ASR  = 3'd6,
        CLR  = 3'd7
    } reg_mode_t;

endpackage : mu0_reg_pkg

// File: rtl/mu0_reg_next.sv
// ---------------------------------------------------------------------------
// mu0_reg_next
// Purely combinational next-state logic for the multi-mode register.
// Given the current contents and the selected mode it produces the value
// the register should take and the carry/borrow/shifted-out bit.
//
// Parameters:
//   WIDTH    : data width in bits (>= 2)
//   STEP     : increment/decrement amount
//   SATURATE : 1 = INC/DEC clamp at all-ones/zero instead of wrapping
//
// Ports:
//   q          in   WIDTH  current register contents
//   d          in   WIDTH  parallel load data
//   ser_in     in   1      fill bit for SHL/SHR
//   mode       in   3      operation select
//   next_q     out  WIDTH  candidate new contents
//   next_carry out  1      candidate new carry
// ---------------------------------------------------------------------------
module mu0_reg_next
    import mu0_reg_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int STEP     = 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    input  reg_mode_t        mode,
    output logic [WIDTH-1:0] next_q,
    output logic             next_carry
);

    // STEP widened by one bit so the top bit of sum/diff is the carry/borrow.
    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // Both operands are below 2**WIDTH, so diff goes negative (top bit set)
    // exactly when q < STEP.
    assign sum  = {1'b0, q} + STEP_EXT;
    assign diff = {1'b0, q} - STEP_EXT;

    always_comb begin
        next_q     = q;
        next_carry = 1'b0;
        case (mode)
            HOLD: begin
                next_q     = q;
                next_carry = 1'b0;
            end
            LOAD: begin
                next_q     = d;
                next_carry = 1'b0;
            end
            INC: begin
                next_carry = sum[WIDTH];
                if (SATURATE && sum[WIDTH]) begin
                    next_q = '1;
                end else begin
                    next_q = sum[WIDTH-1:0];
                end
            end
            DEC: begin
                next_carry = diff[WIDTH];
                if (SATURATE && diff[WIDTH]) begin
                    next_q = '0;
                end else begin
                    next_q = diff[WIDTH-1:0];
                end
            end
            SHL: begin
                next_q     = {q[WIDTH-2:0], ser_in};
                next_carry = q[WIDTH-1];
            end
            SHR: begin
                next_q     = {ser_in, q[WIDTH-1:1]};
                next_carry = q[0];
            end
            ASR: begin
                next_q     = {q[WIDTH-1], q[WIDTH-1:1]};
                next_carry = q[0];
            end
            CLR: begin
                next_q     = '0;
                next_carry = 1'b0;
            end
            default: begin
                next_q     = q;
                next_carry = 1'b0;
            end
        endcase
    end

endmodule : mu0_reg_next

// File: rtl/mu0_reg_multi.sv
// ---------------------------------------------------------------------------
// mu0_reg_multi
// Parametrised multi-mode register for MU0 variants (PC, ACC, shifter).
// Holds Q plus registered Carry/Zero/Neg flags; Zero and Neg always
// describe the Q currently being driven.
//
// Parameters:
//   WIDTH     : data width in bits (>= 2)
//   RESET_VAL : value loaded into Q on Reset
//   STEP      : increment/decrement amount
//   SATURATE  : 1 = INC/DEC clamp instead of wrapping
//
// Ports:
//   Clk    in   1      rising-edge clock
//   Reset  in   1      asynchronous, active-high reset
//   En     in   1      update enable; 0 = everything holds
//   Mode   in   3      operation select (reg_mode_t)
//   D      in   WIDTH  parallel load data
//   SerIn  in   1      fill bit for SHL/SHR
//   Q      out  WIDTH  register contents
//   Carry  out  1      carry/borrow/shifted-out bit
//   Zero   out  1      Q == 0
//   Neg    out  1      Q[WIDTH-1]
// ---------------------------------------------------------------------------
module mu0_reg_multi
    import mu0_reg_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               STEP      = 1,
    parameter bit               SATURATE  = 1'b0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  reg_mode_t        Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SerIn,
    output logic [WIDTH-1:0] Q,
    output logic             Carry,
    output logic             Zero,
    output logic             Neg
);

    logic [WIDTH-1:0] next_q;
    logic             next_carry;

    mu0_reg_next #(
        .WIDTH    (WIDTH),
        .STEP     (STEP),
        .SATURATE (SATURATE)
    ) u_next (
        .q          (Q),
        .d          (D),
        .ser_in     (SerIn),
        .mode       (Mode),
        .next_q     (next_q),
        .next_carry (next_carry)
    );

    // Flags are derived from next_q rather than Q so they land on the same
    // edge as the new value. HOLD leaves the flags alone as well as Q.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Q     <= RESET_VAL;
            Carry <= 1'b0;
            Zero  <= (RESET_VAL == '0);
            Neg   <= RESET_VAL[WIDTH-1];
        end else if (En && (Mode != HOLD)) begin
            Q     <= next_q;
            Carry <= next_carry;
            Zero  <= (next_q == '0);
            Neg   <= next_q[WIDTH-1];
        end
    end

endmodule : mu0_reg_multi

// File: tb/tb_mu0_reg_multi.sv
// ---------------------------------------------------------------------------
// tb_mu0_reg_multi
// Self-checking bench for mu0_reg_multi. Five instances with different
// parameter sets share one stimulus stream; an arithmetic model tracks the
// expected state of each and is compared on every falling edge, with
// hand-computed literal expectations at the interesting points.
// ---------------------------------------------------------------------------
module tb_mu0_reg_multi;
    import mu0_reg_pkg::*;

    localparam int N = 5;

    logic      clk = 1'b0;
    logic      reset = 1'b0;
    logic      en = 1'b0;
    reg_mode_t mode = HOLD;
    logic [15:0] d = 16'h0000;
    logic      ser_in = 1'b0;

    logic [15:0] q0, q1, q2, q3;
    logic [7:0]  q4;
    logic [N-1:0] carry, zero, neg;
    logic [15:0] q_all [N];

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // Per-instance configuration mirrored for the model.
    int     cfg_w    [N] = '{16, 16, 16, 16, 8};
    longint cfg_step [N] = '{1, 1, 4, 4, 1};
    bit     cfg_sat  [N] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    longint cfg_rv   [N] = '{64'h10, 64'h10, 64'h10, 64'h10, 64'hAA};

    longint mq [N];
    bit     mc [N];

    always #5 clk = ~clk;

    mu0_reg_multi #(.WIDTH(16), .RESET_VAL(16'h0010), .STEP(1), .SATURATE(1'b0)) u0 (
        .Clk(clk), .Reset(reset), .En(en), .Mode(mode), .D(d), .SerIn(ser_in),
        .Q(q0), .Carry(carry[0]), .Zero(zero[0]), .Neg(neg[0]));
    mu0_reg_multi #(.WIDTH(16), .RESET_VAL(16'h0010), .STEP(1), .SATURATE(1'b1)) u1 (
        .Clk(clk), .Reset(reset), .En(en), .Mode(mode), .D(d), .SerIn(ser_in),
        .Q(q1), .Carry(carry[1]), .Zero(zero[1]), .Neg(neg[1]));
    mu0_reg_multi #(.WIDTH(16), .RESET_VAL(16'h0010), .STEP(4), .SATURATE(1'b0)) u2 (
        .Clk(clk), .Reset(reset), .En(en), .Mode(mode), .D(d), .SerIn(ser_in),
        .Q(q2), .Carry(carry[2]), .Zero(zero[2]), .Neg(neg[2]));
    mu0_reg_multi #(.WIDTH(16), .RESET_VAL(16'h0010), .STEP(4), .SATURATE(1'b1)) u3 (
        .Clk(clk), .Reset(reset), .En(en), .Mode(mode), .D(d), .SerIn(ser_in),
        .Q(q3), .Carry(carry[3]), .Zero(zero[3]), .Neg(neg[3]));
    mu0_reg_multi #(.WIDTH(8), .RESET_VAL(8'hAA), .STEP(1), .SATURATE(1'b0)) u4 (
        .Clk(clk), .Reset(reset), .En(en), .Mode(mode), .D(d[7:0]), .SerIn(ser_in),
        .Q(q4), .Carry(carry[4]), .Zero(zero[4]), .Neg(neg[4]));

    always_comb begin
        q_all[0] = q0;
        q_all[1] = q1;
        q_all[2] = q2;
        q_all[3] = q3;
        q_all[4] = {8'h00, q4};
    end

    // Model: plain integer arithmetic on the register value.
    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            mq[i] = cfg_rv[i];
            mc[i] = 1'b0;
        end
    endtask

    task automatic modelStep(input int i);
        longint top_v, mask, s;
        mask  = (longint'(1) << cfg_w[i]) - 1;
        top_v = longint'(1) << (cfg_w[i] - 1);
        case (mode)
            LOAD: begin mq[i] = longint'(d) & mask; mc[i] = 1'b0; end
            INC: begin
                s = mq[i] + cfg_step[i];
                mc[i] = (s > mask);
                if (s > mask) mq[i] = cfg_sat[i] ? mask : s - (mask + 1);
                else          mq[i] = s;
            end
            DEC: begin
                mc[i] = (mq[i] < cfg_step[i]);
                if (mq[i] < cfg_step[i]) mq[i] = cfg_sat[i] ? 0 : mq[i] + (mask + 1) - cfg_step[i];
                else                     mq[i] = mq[i] - cfg_step[i];
            end
            SHL: begin
                mc[i] = (mq[i] & top_v) != 0;
                mq[i] = ((mq[i] * 2) + longint'(ser_in)) & mask;
            end
            SHR: begin
                mc[i] = (mq[i] % 2) != 0;
                mq[i] = (mq[i] / 2) + (ser_in ? top_v : 0);
            end
            ASR: begin
                mc[i] = (mq[i] % 2) != 0;
                mq[i] = (mq[i] / 2) + (mq[i] & top_v);
            end
            CLR: begin mq[i] = 0; mc[i] = 1'b0; end
            default: ;
        endcase
    endtask

    always @(posedge reset) modelReset();

    always @(posedge clk) begin
        if (!reset && en && mode != HOLD) begin
            for (int i = 0; i < N; i++) modelStep(i);
        end
    end

    task automatic checkOutput(input int i);
        longint top_v;
        bit ez, en_exp;
        top_v  = longint'(1) << (cfg_w[i] - 1);
        ez     = (mq[i] == 0);
        en_exp = (mq[i] & top_v) != 0;
        checks++;
        if ({48'h0, q_all[i]} !== mq[i] || carry[i] !== mc[i] || zero[i] !== ez || neg[i] !== en_exp) begin
            failures++;
            $display("[TB] FAIL model u%0d t=%0t: Q=%h C=%b Z=%b N=%b required Q=%h C=%b Z=%b N=%b",
                     i, $time, q_all[i], carry[i], zero[i], neg[i], mq[i][15:0], mc[i], ez, en_exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < N; i++) checkOutput(i);
        end
    end

    task automatic checkLiteral(input string name, input int i, input logic [15:0] eq,
                                input logic ec, input logic ez, input logic eneg);
        checks++;
        if (q_all[i] !== eq || carry[i] !== ec || zero[i] !== ez || neg[i] !== eneg) begin
            failures++;
            $display("[TB] FAIL %s u%0d: Q=%h C=%b Z=%b N=%b required Q=%h C=%b Z=%b N=%b",
                     name, i, q_all[i], carry[i], zero[i], neg[i], eq, ec, ez, eneg);
        end
    endtask

    // One call = one clock: inputs change just after a falling edge and
    // the call returns just after the following falling edge.
    task automatic applyStimulus(input logic e, input reg_mode_t m, input logic [15:0] dv, input logic s);
        en = e; mode = m; d = dv; ser_in = s;
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset pulsed between clocks; outputs must follow immediately.
        #2 reset = 1'b1;
        #1;
        checkLiteral("reset_async", 0, 16'h0010, 1'b0, 1'b0, 1'b0);
        checkLiteral("reset_async_w8", 4, 16'h00AA, 1'b0, 1'b0, 1'b1);
        #1 reset = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        #1;

        applyStimulus(1'b1, LOAD, 16'h8000, 1'b0);
        checkLiteral("load_8000", 0, 16'h8000, 1'b0, 1'b0, 1'b1);

        applyStimulus(1'b1, LOAD, 16'hFFFF, 1'b0);
        applyStimulus(1'b1, INC, 16'h0000, 1'b0);
        checkLiteral("inc_wrap", 0, 16'h0000, 1'b1, 1'b1, 1'b0);
        checkLiteral("inc_sat", 1, 16'hFFFF, 1'b1, 1'b0, 1'b1);

        applyStimulus(1'b1, LOAD, 16'h0003, 1'b0);
        applyStimulus(1'b1, DEC, 16'h0000, 1'b0);
        checkLiteral("dec_wrap_step4", 2, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        checkLiteral("dec_sat_step4", 3, 16'h0000, 1'b1, 1'b1, 1'b0);

        applyStimulus(1'b1, LOAD, 16'h8001, 1'b0);
        applyStimulus(1'b1, SHL, 16'h0000, 1'b1);
        checkLiteral("shl", 0, 16'h0003, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, SHR, 16'h0000, 1'b0);
        checkLiteral("shr", 0, 16'h0001, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, LOAD, 16'h8002, 1'b0);
        applyStimulus(1'b1, ASR, 16'h0000, 1'b0);
        checkLiteral("asr", 0, 16'hC001, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, SHR, 16'h0000, 1'b1);
        checkLiteral("shr_fill1", 0, 16'hE000, 1'b1, 1'b0, 1'b1);

        // Enable low must freeze everything, including a pending carry.
        applyStimulus(1'b1, LOAD, 16'h1234, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, CLR, 16'h0000, 1'b0);
        checkLiteral("en_low_hold", 0, 16'h1234, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, HOLD, 16'hFFFF, 1'b1);
        checkLiteral("mode_hold", 0, 16'h1234, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, CLR, 16'h0000, 1'b0);
        checkLiteral("clr", 0, 16'h0000, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, DEC, 16'h0000, 1'b0);
        checkLiteral("dec_zero_wrap", 0, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        checkLiteral("dec_zero_sat", 1, 16'h0000, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, INC, 16'h0000, 1'b0);
        checkLiteral("en_low_carry_hold", 0, 16'hFFFF, 1'b1, 1'b0, 1'b1);

        // Reset in the middle of an INC run on the 8-bit instance.
        applyStimulus(1'b1, LOAD, 16'h0005, 1'b0);
        applyStimulus(1'b1, INC, 16'h0000, 1'b0);
        checkLiteral("w8_inc", 4, 16'h0006, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        checkLiteral("w8_reset_mid", 4, 16'h00AA, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkLiteral("w8_reset_held", 4, 16'h00AA, 1'b0, 1'b0, 1'b1);
        #2 reset = 1'b0;
        @(negedge clk);
        #1;
        checkLiteral("w8_first_inc", 4, 16'h00AB, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, LOAD, 16'h00FF, 1'b0);
        applyStimulus(1'b1, INC, 16'h0000, 1'b0);
        checkLiteral("w8_inc_wrap", 4, 16'h0000, 1'b1, 1'b1, 1'b0);

        applyStimulus(1'b0, HOLD, 16'h0000, 1'b0);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule : tb_mu0_reg_multi
